// File: rtl/z88_video_pkg.sv
// z88_video_pkg: shared VGA timing, LCD window geometry, colours and VRAM address type
package z88_video_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int         V_SCALE_LOG2 = 2;
    localparam logic [9:0] V_TOP        = 10'd112;
    localparam logic [9:0] LCD_LINES    = 10'd64;
    localparam logic [7:0] LCD_NIBBLES  = 8'd160;
    localparam logic [9:0] V_BOT        = V_TOP + (LCD_LINES << V_SCALE_LOG2);

    localparam logic [11:0] RGB_LIT   = 12'h113;
    localparam logic [11:0] RGB_UNLIT = 12'hADB;
    localparam logic [11:0] RGB_BLANK = 12'h000;

    typedef logic [13:0] vram_addr_t;

    // LCD line shown on display row v (caller guarantees v is inside the window)
    function automatic logic [5:0] lcd_line(input logic [9:0] v);
        return 6'((v - V_TOP) >> V_SCALE_LOG2);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster counters with registered syncs, active-video and start-of-frame
module vga_timing
    import z88_video_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ce_i,
    output logic [9:0] hcnt_o,
    output logic [9:0] vcnt_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       de_o,
    output logic       sof_o
);

    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       hsync_n_q, vsync_n_q, de_q, sof_q;

    // Next raster position: hcnt wraps every line, vcnt steps only on that wrap
    always_comb begin
        hcnt_d = (hcnt_q == H_TOTAL - 10'd1) ? '0 : hcnt_q + 10'd1;
        vcnt_d = (hcnt_q != H_TOTAL - 10'd1) ? vcnt_q :
                 (vcnt_q == V_TOTAL - 10'd1) ? '0 : vcnt_q + 10'd1;
    end

    // Outputs describe the position held at this enable, so they trail the counters by one ce
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            de_q      <= 1'b0;
            sof_q     <= 1'b0;
        end else if (ce_i) begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hsync_n_q <= !(hcnt_q >= H_ACTIVE + H_FP && hcnt_q < H_ACTIVE + H_FP + H_SYNC);
            vsync_n_q <= !(vcnt_q >= V_ACTIVE + V_FP && vcnt_q < V_ACTIVE + V_FP + V_SYNC);
            de_q      <= hcnt_q < H_ACTIVE && vcnt_q < V_ACTIVE;
            sof_q     <= hcnt_q == '0 && vcnt_q == '0;
        end
    end

    assign hcnt_o    = hcnt_q;
    assign vcnt_o    = vcnt_q;
    assign hsync_n_o = hsync_n_q;
    assign vsync_n_o = vsync_n_q;
    assign de_o      = de_q;
    assign sof_o     = sof_q;

endmodule

// File: rtl/lcd_scanout.sv
// lcd_scanout: scans the Z88 nibble VRAM out as a 4x-scaled centred window on 640x480 video (LCD_COLOR_EN adds rgb)
module lcd_scanout
    import z88_video_pkg::*;
(
    input  logic        mck,
    input  logic        rin_n,
    input  logic        pix_ce,
    input  logic        lcdon,
    output logic [13:0] vram_a,
    input  logic [3:0]  vram_di,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic        pix,
`ifdef LCD_COLOR_EN
    output logic [11:0] rgb,
`endif
    output logic        sof
);

    logic [9:0] hcnt, vcnt, vnext;
    logic       in_cur, in_next, fetch_first, fetch_run, vis, pix_d, pix_q;
    vram_addr_t vram_a_q, vram_a_d;
    logic [3:0] buf_q, buf_d, shift_q, shift_d;
`ifdef LCD_COLOR_EN
    logic [11:0] rgb_q, rgb_d;
`endif

    vga_timing u_timing (
        .clk_i     (mck),
        .rst_ni    (rin_n),
        .ce_i      (pix_ce),
        .hcnt_o    (hcnt),
        .vcnt_o    (vcnt),
        .hsync_n_o (hsync_n),
        .vsync_n_o (vsync_n),
        .de_o      (de),
        .sof_o     (sof)
    );

    // Nibble k is addressed two ces before its first pixel, latched one ce before, shifted out from 4k
    always_comb begin
        vnext       = (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
        in_cur      = vcnt >= V_TOP && vcnt < V_BOT;
        in_next     = vnext >= V_TOP && vnext < V_BOT;
        fetch_first = hcnt == H_TOTAL - 10'd2 && in_next;
        fetch_run   = hcnt[1:0] == 2'd2 && hcnt[9:2] < LCD_NIBBLES - 8'd1 && in_cur;
        vram_a_d    = fetch_first ? {lcd_line(vnext), 8'd0} :
                      fetch_run   ? {lcd_line(vcnt), hcnt[9:2] + 8'd1} : vram_a_q;
        buf_d       = hcnt[1:0] == 2'd3 ? vram_di : buf_q;
        shift_d     = hcnt[1:0] == 2'd0 ? buf_q : shift_q;
        vis         = in_cur && hcnt < H_ACTIVE;
        pix_d       = vis && lcdon && (hcnt[1:0] == 2'd0 ? buf_q[3] : shift_q[~hcnt[1:0]]);
`ifdef LCD_COLOR_EN
        rgb_d       = !vis ? RGB_BLANK : pix_d ? RGB_LIT : RGB_UNLIT;
`endif
    end

    // Fetch address, nibble buffer, shifter and pixel outputs advance only on pixel enables
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            vram_a_q <= '0;
            buf_q    <= '0;
            shift_q  <= '0;
            pix_q    <= 1'b0;
`ifdef LCD_COLOR_EN
            rgb_q    <= RGB_BLANK;
`endif
        end else if (pix_ce) begin
            vram_a_q <= vram_a_d;
            buf_q    <= buf_d;
            shift_q  <= shift_d;
            pix_q    <= pix_d;
`ifdef LCD_COLOR_EN
            rgb_q    <= rgb_d;
`endif
        end
    end

    assign vram_a = vram_a_q;
    assign pix    = pix_q;
`ifdef LCD_COLOR_EN
    assign rgb    = rgb_q;
`endif

endmodule

// File: tb/tb_lcd_scanout.sv
// tb_lcd_scanout: randomized scoreboard bench for lcd_scanout against a raster-level reference model
module tb_lcd_scanout;

`ifdef LCD_COLOR_EN
    localparam int W = 31;
`else
    localparam int W = 19;
`endif

    logic        mck = 1'b0, rin_n = 1'b0, pix_ce = 1'b0, lcdon = 1'b1;
    logic [3:0]  vram_di;
    logic [13:0] vram_a;
    logic        hsync_n, vsync_n, de, pix, sof;
    logic [W-1:0] act, rst_vec, e;
`ifdef LCD_COLOR_EN
    logic [11:0] rgb;
`endif

    logic [3:0]   mem [16384];
    logic [W-1:0] q[$];
    int checks = 0, errors = 0;
    int h = 0, v = 0;
    logic [13:0] exp_addr = '0;
    logic stat_en = 1'b0;
    int sof_cnt = 0, hs_low = 0, vs_low = 0;

    always #5 mck = ~mck;

    always @(posedge mck) vram_di <= mem[vram_a];

    lcd_scanout dut (
        .mck     (mck),
        .rin_n   (rin_n),
        .pix_ce  (pix_ce),
        .lcdon   (lcdon),
        .vram_a  (vram_a),
        .vram_di (vram_di),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n),
        .de      (de),
        .pix     (pix),
`ifdef LCD_COLOR_EN
        .rgb     (rgb),
`endif
        .sof     (sof)
    );

`ifdef LCD_COLOR_EN
    assign act = {hsync_n, vsync_n, de, pix, sof, vram_a, rgb};
`else
    assign act = {hsync_n, vsync_n, de, pix, sof, vram_a};
`endif

    // Expected outputs for raster position (h,v): pixel bit taken straight from the LCD image
    function automatic logic [W-1:0] model(input int hh, input int vv, input logic on, input logic [13:0] a);
        logic vis, b;
        logic [3:0] nib;
        vis = vv >= 112 && vv < 368 && hh < 640;
        nib = vis ? mem[14'((vv - 112) / 4 * 256 + hh / 4)] : 4'd0;
        b = vis && on && nib[3 - hh % 4];
`ifdef LCD_COLOR_EN
        return {!(hh >= 656 && hh <= 751), !(vv == 490 || vv == 491), hh < 640 && vv < 480, b,
                hh == 0 && vv == 0, a, !vis ? 12'h000 : b ? 12'h113 : 12'hADB};
`else
        return {!(hh >= 656 && hh <= 751), !(vv == 490 || vv == 491), hh < 640 && vv < 480, b,
                hh == 0 && vv == 0, a};
`endif
    endfunction

    task automatic check_vec(input string name, input logic [W-1:0] ev);
        checks++;
        if (act !== ev) begin
            errors++;
            $display("FAIL %s: got %h need %h", name, act, ev);
        end
    endtask

    task automatic check_int(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            errors++;
            $display("FAIL %s: got %0d need %0d", name, got, need);
        end
    endtask

    // One ce every gap mck; the address expected after a ce is the nibble whose first pixel lies 2 ces ahead
    task automatic run(input int n, input int gap);
        int h2, v2;
        for (int i = 0; i < n; i++) begin
            @(negedge mck);
            pix_ce = 1'b1;
            lcdon  = (v >= 200 && v < 210) ? 1'b0 : ($urandom_range(0, 31) != 0);
            h2 = h + 2;
            v2 = v;
            if (h2 >= 800) begin
                h2 -= 800;
                v2 = (v + 1) % 525;
            end
            if (h2 % 4 == 0 && h2 < 640 && v2 >= 112 && v2 < 368)
                exp_addr = 14'((v2 - 112) / 4 * 256 + h2 / 4);
            q.push_back(model(h, v, lcdon, exp_addr));
            h++;
            if (h == 800) begin
                h = 0;
                v = (v + 1) % 525;
            end
            @(negedge mck);
            pix_ce = 1'b0;
            repeat (gap - 2) @(negedge mck);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge mck);
        rin_n = 1'b0;
        #1;
        check_vec(name, rst_vec);
        q.delete();
        h = 0;
        v = 0;
        exp_addr = '0;
        @(negedge mck);
        rin_n = 1'b1;
    endtask

    // Monitor: every ce the DUT presents one raster position, compared against the oldest expectation
    always @(posedge mck) begin
        if (pix_ce && rin_n) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got output with no expectation, need queued entry");
            end else begin
                e = q.pop_front();
                check_vec("scoreboard", e);
            end
            if (stat_en) begin
                sof_cnt += int'(sof);
                hs_low  += int'(!hsync_n);
                vs_low  += int'(!vsync_n);
            end
        end
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

    initial begin
        rst_vec = '0;
        rst_vec[W-1] = 1'b1;
        rst_vec[W-2] = 1'b1;
        for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom_range(0, 15));
        for (int i = 22 * 256; i < 25 * 256; i++) mem[i] = 4'hF;
        mem[0] = 4'b1010;
        mem[1] = 4'b1111;
        repeat (3) @(negedge mck);
        #1;
        check_vec("reset_state", rst_vec);
        @(negedge mck);
        rin_n = 1'b1;
        stat_en = 1'b1;
        run(420000, 2);
        stat_en = 1'b0;
        check_int("sof_per_frame", sof_cnt, 1);
        check_int("hsync_low_ces", hs_low, 96 * 525);
        check_int("vsync_low_ces", vs_low, 2 * 800);
        run(2000, 2);
        do_reset("reset_before_cadence3");
        run(1100, 3);
        do_reset("midline_reset");
        run(2400, 3);
        repeat (4) @(negedge mck);
        check_int("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
